// File: rtl/bram_arb_pkg.sv
// Shared types and defaults for the BRAM port arbiter.
// Owner/state encodings plus the word-address legality check.
package bram_arb_pkg;

   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;
   typedef enum logic {WAIT_RDY, RUN} state_e;

   localparam int WORD_BYTES       = 4;
   localparam int DEF_MEM_DEPTH    = 1096;
   localparam int DEF_STARVE_LIMIT = 4;

   // Legal iff the word index fits in the memory; low byte bits are ignored.
   function automatic logic addr_legal(input logic [31:0] addr, input int depth);
      return (addr >> $clog2(WORD_BYTES)) < 32'(depth);
   endfunction

endpackage

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between instruction fetch and load/store, data first,
// with a bounded run of data grants while fetch waits.
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int MEM_DEPTH    = DEF_MEM_DEPTH,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic        clkb,
   input  logic        rstb,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        d_req,
   input  logic [3:0]  d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        bram_en,
   output logic [3:0]  bram_we,
   output logic [31:0] bram_addr,
   output logic [31:0] bram_din,
   input  logic [31:0] bram_dout,
   input  logic        bram_rst_busy
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_e      state_reg, state_next;
   owner_e      owner_reg, owner_next;
   logic        err_reg, err_next;
   logic [3:0]  starve_cnt_reg, starve_cnt_next;
   logic        grant_ok, d_win, any_gnt, g_legal, wr_issue;
   logic [31:0] g_addr;

   always_ff @(posedge clkb) begin
      if (rstb) begin
         state_reg      <= WAIT_RDY;
         owner_reg      <= OWN_NONE;
         err_reg        <= 1'b0;
         starve_cnt_reg <= '0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         err_reg        <= err_next;
         starve_cnt_reg <= starve_cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         WAIT_RDY: if (!bram_rst_busy) state_next = RUN;
         RUN:      if (bram_rst_busy)  state_next = WAIT_RDY;
      endcase

      // Reset is gated in directly so a grant never leaks during the first reset cycle.
      grant_ok = (state_reg == RUN) && !bram_rst_busy && !rstb;
      d_win    = d_req && (!if_req || (starve_cnt_reg != LIMIT));
      d_gnt    = grant_ok && d_win;
      if_gnt   = grant_ok && if_req && !d_win;
      any_gnt  = d_gnt || if_gnt;

      g_addr    = d_gnt ? d_addr : if_addr;
      g_legal   = addr_legal(g_addr, MEM_DEPTH);
      bram_en   = any_gnt && g_legal;
      bram_addr = any_gnt ? g_addr : '0;
      bram_din  = d_gnt ? d_wdata : '0;
      wr_issue  = bram_en && d_gnt;

      owner_next = d_gnt ? OWN_D : (if_gnt ? OWN_IF : OWN_NONE);
      err_next   = any_gnt && !g_legal;

      starve_cnt_next = starve_cnt_reg;
      if (!if_req || if_gnt)
         starve_cnt_next = '0;
      else if (d_gnt && (starve_cnt_reg != LIMIT))
         starve_cnt_next = starve_cnt_reg + 4'd1;
   end

   for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_we
      assign bram_we[gi] = wr_issue & d_we[gi];
   end

   // Error responses carry zero data regardless of what the BRAM holds on doutb.
   assign if_rvalid = (owner_reg == OWN_IF);
   assign if_err    = if_rvalid && err_reg;
   assign if_rdata  = (if_rvalid && !err_reg) ? bram_dout : '0;

   assign d_rvalid  = (owner_reg == OWN_D);
   assign d_err     = d_rvalid && err_reg;
   assign d_rdata   = (d_rvalid && !err_reg) ? bram_dout : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter with a write-first BRAM model;
// stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_bram_port_arbiter;

   localparam int MEM_DEPTH = 1096;
   localparam int STARVE    = 4;

   typedef struct {
      bit          is_d;
      logic [31:0] rdata;
      bit          err;
      int          cyc;
   } exp_t;

   logic        clkb, rstb;
   logic        if_req, if_gnt, if_rvalid, if_err;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_gnt, d_rvalid, d_err;
   logic [3:0]  d_we;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        bram_en, bram_rst_busy;
   logic [3:0]  bram_we;
   logic [31:0] bram_addr, bram_din, bram_dout;

   logic [31:0] mem [0:MEM_DEPTH-1];
   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cycle    = 0;

   bram_port_arbiter dut (
      .clkb(clkb), .rstb(rstb),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_din(bram_din), .bram_dout(bram_dout), .bram_rst_busy(bram_rst_busy)
   );

   initial clkb = 1'b0;
   always #5 clkb = ~clkb;

   always @(posedge clkb) cycle <= cycle + 1;

   // Write-first BRAM: a store returns dinb on doutb.
   always @(posedge clkb) begin
      if (bram_en) begin
         bram_dout <= (bram_we != 4'b0) ? bram_din : mem[bram_addr[12:2]];
         for (int b = 0; b < 4; b++)
            if (bram_we[b]) mem[bram_addr[12:2]][8*b +: 8] <= bram_din[8*b +: 8];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cycle);
      end
   endtask

   task automatic push_exp(input bit is_d, input logic [31:0] rdata, input bit err);
      exp_t e;
      e.is_d  = is_d;
      e.rdata = rdata;
      e.err   = err;
      e.cyc   = cycle;
      sb.push_back(e);
      $display("issue  cyc=%0d port=%s exp_rdata=%h exp_err=%0b", cycle, is_d ? "D " : "IF", rdata, err);
   endtask

   always @(negedge clkb) begin
      if (if_rvalid && d_rvalid) begin
         chk("dual_rvalid", 32'(if_rvalid && d_rvalid), 32'd0);
      end else if (if_rvalid || d_rvalid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got if_rvalid=%0b d_rvalid=%0b, expected none (cycle %0d)",
                     if_rvalid, d_rvalid, cycle);
         end else begin
            exp_t e;
            e = sb.pop_front();
            $display("resp   cyc=%0d port=%s rdata=%h err=%0b", cycle, d_rvalid ? "D " : "IF",
                     d_rvalid ? d_rdata : if_rdata, d_rvalid ? d_err : if_err);
            chk("rsp_port",  32'(d_rvalid), 32'(e.is_d));
            chk("rsp_cycle", 32'(cycle), 32'(e.cyc + 1));
            chk("rsp_data",  d_rvalid ? d_rdata : if_rdata, e.rdata);
            chk("rsp_err",   32'(d_rvalid ? d_err : if_err), 32'(e.err));
         end
      end
   end

   // Holds one request until granted, checks the issued pins, then drops it.
   task automatic issue(input bit is_d, input logic [31:0] addr, input logic [3:0] we,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit exp_err);
      int  waitc;
      bit  granted;
      waitc = 0;
      if (is_d) begin
         d_req = 1'b1; d_addr = addr; d_we = we; d_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      @(negedge clkb);
      granted = is_d ? d_gnt : if_gnt;
      while (!granted && waitc < 20) begin
         @(negedge clkb);
         waitc++;
         granted = is_d ? d_gnt : if_gnt;
      end
      chk("gnt_seen", 32'(granted), 32'd1);
      if (granted) begin
         chk("issue_en",   32'(bram_en), 32'(!exp_err));
         chk("issue_addr", bram_addr, addr);
         chk("issue_we",   32'(bram_we), (is_d && !exp_err) ? 32'(we) : 32'd0);
         push_exp(is_d, exp_rdata, exp_err);
      end
      @(posedge clkb); #1;
      if (is_d) d_req = 1'b0; else if_req = 1'b0;
   endtask

   // Both requesters held; counter assumed clear at entry.
   task automatic both_pattern(input int n, input logic [31:0] if_exp, input logic [31:0] d_exp);
      for (int k = 0; k < n; k++) begin
         bit exp_i;
         exp_i = ((k % (STARVE + 1)) == STARVE);
         @(negedge clkb);
         chk("arb_if_gnt", 32'(if_gnt), 32'(exp_i));
         chk("arb_d_gnt",  32'(d_gnt),  32'(!exp_i));
         push_exp(!exp_i, exp_i ? if_exp : d_exp, 1'b0);
         @(posedge clkb); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 32'hA500_0000 | 32'(i);
      mem[0] = 32'h0000_0013;
      mem[4] = 32'h0000_0013;
      bram_dout = '0;
      rstb = 1'b1; bram_rst_busy = 1'b0;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = '0; d_addr = '0; d_wdata = '0;

      // Reset state
      repeat (3) @(posedge clkb);
      #1;
      @(negedge clkb);
      chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rst_d_rvalid",  32'(d_rvalid),  32'd0);
      chk("rst_if_err",    32'(if_err),    32'd0);
      chk("rst_d_err",     32'(d_err),     32'd0);
      chk("rst_bram_en",   32'(bram_en),   32'd0);

      // Busy after reset blocks the fetch until the cycle after busy falls
      @(posedge clkb); #1;
      rstb = 1'b0; bram_rst_busy = 1'b1; if_req = 1'b1; if_addr = 32'h0;
      repeat (3) begin
         @(negedge clkb);
         chk("busy_no_gnt", 32'(if_gnt), 32'd0);
         @(posedge clkb); #1;
      end
      bram_rst_busy = 1'b0;
      @(negedge clkb);
      chk("rdy_no_gnt", 32'(if_gnt), 32'd0);
      @(posedge clkb); #1;
      @(negedge clkb);
      chk("first_if_gnt", 32'(if_gnt), 32'd1);
      chk("first_en",     32'(bram_en), 32'd1);
      push_exp(1'b0, 32'h0000_0013, 1'b0);
      @(posedge clkb); #1;
      if_req = 1'b0;

      // Byte-masked store, then read back the merged word
      issue(1'b1, 32'h10, 4'b0011, 32'hAABB_CCDD, 32'hAABB_CCDD, 1'b0);
      issue(1'b1, 32'h10, 4'b0000, 32'h0,        32'h0000_CCDD, 1'b0);

      // Starvation limit: D,D,D,D,I repeating
      if_addr = 32'h4; d_addr = 32'h8; d_we = 4'b0;
      if_req = 1'b1; d_req = 1'b1;
      both_pattern(10, 32'hA500_0001, 32'hA500_0002);
      if_req = 1'b0; d_req = 1'b0;

      // Out-of-range on both ports
      issue(1'b1, 32'h0000_1120, 4'b0, 32'h0, 32'h0, 1'b1);
      issue(1'b0, 32'hFFFF_FFF0, 4'b0, 32'h0, 32'h0, 1'b1);

      // Busy in RUN: in-flight response still delivered, no grant, then re-grant
      d_req = 1'b1; d_addr = 32'h111C; d_we = 4'b0;
      @(negedge clkb);
      chk("last_word_gnt", 32'(d_gnt), 32'd1);
      push_exp(1'b1, 32'hA500_0447, 1'b0);
      @(posedge clkb); #1;
      bram_rst_busy = 1'b1;
      @(negedge clkb);
      chk("busy_run_no_gnt", 32'(d_gnt), 32'd0);
      chk("busy_run_rvalid", 32'(d_rvalid), 32'd1);
      @(posedge clkb); #1;
      bram_rst_busy = 1'b0;
      issue(1'b1, 32'h111C, 4'b0, 32'h0, 32'hA500_0447, 1'b0);

      // Fetch granted, reset on the following edge drops its response
      if_req = 1'b1; if_addr = 32'h0;
      @(negedge clkb);
      chk("pre_rst_if_gnt", 32'(if_gnt), 32'd1);
      rstb = 1'b1;
      d_req = 1'b1; d_addr = 32'h8;
      @(negedge clkb);
      chk("rst_drop_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rst_no_if_gnt",      32'(if_gnt),    32'd0);
      chk("rst_no_d_gnt",       32'(d_gnt),     32'd0);
      @(posedge clkb); #1;
      rstb = 1'b0;
      @(negedge clkb);
      chk("post_rst_wait_gnt", 32'(if_gnt || d_gnt), 32'd0);
      @(posedge clkb); #1;
      both_pattern(3, 32'h0000_0013, 32'hA500_0002);

      // Reset with a non-zero counter, then the full 4-D run must reappear
      @(negedge clkb);
      chk("pre_rst_d_gnt", 32'(d_gnt), 32'd1);
      rstb = 1'b1;
      @(negedge clkb);
      chk("rst_drop_d_rvalid", 32'(d_rvalid), 32'd0);
      @(posedge clkb); #1;
      rstb = 1'b0;
      @(negedge clkb);
      chk("post_rst2_wait_gnt", 32'(if_gnt || d_gnt), 32'd0);
      @(posedge clkb); #1;
      both_pattern(5, 32'h0000_0013, 32'hA500_0002);
      if_req = 1'b0; d_req = 1'b0;

      // Back-to-back fetch then data, no cross-routing
      if_req = 1'b1; if_addr = 32'h0;
      @(negedge clkb);
      chk("b2b_if_gnt", 32'(if_gnt), 32'd1);
      push_exp(1'b0, 32'h0000_0013, 1'b0);
      @(posedge clkb); #1;
      if_req = 1'b0; d_req = 1'b1; d_addr = 32'h4; d_we = 4'b0;
      @(negedge clkb);
      chk("b2b_d_gnt", 32'(d_gnt), 32'd1);
      push_exp(1'b1, 32'hA500_0001, 1'b0);
      @(posedge clkb); #1;
      d_req = 1'b0;

      repeat (4) @(negedge clkb);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single port of the core's unified instruction/data BRAM between two requesters: the instruction fetch unit (read-only) and the load/store unit (read/write with byte enables).
- Arbitrates at most one access per cycle using data-priority with a fetch anti-starvation limit.
- Drives the BRAM enable, write-enable, address and data pins, and routes the 1-cycle-latency read data back to the requester that issued the access.
- Rejects out-of-range addresses with an error response and never forwards them to the BRAM.

Parameters:
MEM_DEPTH, 1096, BRAM depth in 32-bit words; a byte address is legal iff addr[31:2] < MEM_DEPTH.
STARVE_LIMIT, 4, max consecutive data grants while fetch is requesting; range 1..15.

Ports:
clkb  in  1  clock, all state on posedge
rstb  in  1  synchronous active-high reset
if_req  in  1  fetch request, held until if_gnt
if_addr  in  32  fetch byte address
if_gnt  out  1  fetch accepted this cycle (combinational)
if_rvalid  out  1  fetch response valid (registered)
if_rdata  out  32  fetch read data
if_err  out  1  fetch response is out-of-range error
d_req  in  1  data request, held until d_gnt
d_we  in  4  byte write enables; 0 = read
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_gnt  out  1  data accepted this cycle (combinational)
d_rvalid  out  1  data response valid, for reads and writes (registered)
d_rdata  out  32  load data, or echoed store data on a write
d_err  out  1  data response is out-of-range error
bram_en  out  1  BRAM enb
bram_we  out  4  BRAM web
bram_addr  out  32  BRAM addrb, byte address
bram_din  out  32  BRAM dinb
bram_dout  in  32  BRAM doutb, valid 1 cycle after an enabled access
bram_rst_busy  in  1  BRAM rstb_busy; no grants while high

Behaviour:
- States: WAIT_RDY, RUN.
  - rstb forces WAIT_RDY.
  - WAIT_RDY -> RUN on the first cycle with rstb=0 and bram_rst_busy=0.
  - RUN -> WAIT_RDY if bram_rst_busy rises.
  - No grants are issued in WAIT_RDY.
- Reset values: if_rvalid=0, d_rvalid=0, if_err=0, d_err=0, starvation counter=0, response-owner register=NONE.
- Combinational outputs are 0 whenever there is no grant: if_gnt, d_gnt, bram_en, bram_we.
- Arbitration in RUN, evaluated each cycle:
  - Only d_req: grant data.
  - Only if_req: grant fetch.
  - Both requesting: grant data unless the counter equals STARVE_LIMIT, in which case grant fetch.
  - Counter: increments on a data grant while if_req=1; clears on any fetch grant or any cycle with if_req=0; saturates at STARVE_LIMIT.
- Issue (same cycle as the grant): for a legal address, bram_en=1, bram_addr=granted address, and bram_we / bram_din come from the data port (fetch drives bram_we=0, bram_din=0). For an illegal address, bram_en=0 and the owner is recorded with an error flag.
- Response, exactly 1 cycle after the grant (registered owner and error flag):
  - Owner's rvalid=1.
  - rdata = bram_dout, or 0 on error.
  - err = error flag.
  - The other port's rvalid=0.
- Writes: the BRAM returns dinb on doutb, so d_rdata equals the stored word and d_rvalid acknowledges the store.
- Throughput: one access per cycle, back-to-back grants allowed. Responses return strictly in grant order. There is no response backpressure; requesters must accept rvalid.
- The address is passed through unmodified; misaligned low bits are ignored (word access).
- rstb mid-operation: an in-flight response is dropped (rvalid=0 the next cycle), the counter clears, and no grant is issued during reset.
- bram_rst_busy high in RUN: no grant that cycle; a response already in flight is still delivered.

Decomposition:
- Package bram_arb_pkg holds:
  - typedef owner_e {OWN_NONE, OWN_IF, OWN_D}
  - typedef state_e {WAIT_RDY, RUN}
  - WORD_BYTES=4
  - default MEM_DEPTH and STARVE_LIMIT
- No sub-module: a single flat module is natural.

Test Plan:
- Reset, then bram_rst_busy=1 for 3 cycles with if_req=1 -> no if_gnt until the cycle after busy falls; if_rvalid exactly 1 cycle after the grant with if_rdata=DMEM[0] (preload 0x00000013).
- d_req write: d_addr=0x10, d_we=4'b0011, d_wdata=0xAABBCCDD over 0x00000013 -> d_rvalid next cycle with d_rdata=0xAABBCCDD; a later read of 0x10 returns 0x0000CCDD.
- if_req and d_req both held continuously, STARVE_LIMIT=4 -> grant pattern D,D,D,D,I repeating; response owners follow the same order with 1-cycle latency.
- d_addr=4*MEM_DEPTH (0x1120) read -> d_gnt=1, bram_en=0, next cycle d_rvalid=1, d_err=1, d_rdata=0.
- Fetch granted, rstb asserted the following cycle -> if_rvalid stays 0, no grants while reset is high, counter back to 0.
- Back-to-back reads, fetch 0x0 then data 0x4 on consecutive cycles -> if_rvalid then d_rvalid on consecutive cycles, each with the correct word and no cross-routing.
